// File: rtl/led_seq_ctrl.sv
// Sequencing FSM for the LED shift-register datapath: load/shift/direction strobes,
// flash blanking and a button-driven colour select. Optional macro: LED_SEQ_DEBOUNCE_EN.
module led_seq_ctrl #(
    parameter int NLEDS           = 4,
    parameter int POS_W           = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             i_rst,
    input  logic             i_tick,
    input  logic             i_enable,
    input  logic [1:0]       i_mode,
    input  logic             i_color_btn,
    output logic             o_shift,
    output logic             o_dir,
    output logic             o_load,
    output logic [NLEDS-1:0] o_load_data,
    output logic             o_blank,
    output logic [2:0]       o_color_sel,
    output logic [POS_W-1:0] o_pos
);

    typedef enum logic [1:0] {
        ST_LOAD = 2'b00,
        ST_RUN  = 2'b01,
        ST_HOLD = 2'b10
    } state_t;

    localparam logic [POS_W-1:0] POS_MAX  = POS_W'(NLEDS - 1);
    localparam logic [NLEDS-1:0] SEED_LO  = {{(NLEDS-1){1'b0}}, 1'b1};
    localparam logic [NLEDS-1:0] SEED_HI  = {1'b1, {(NLEDS-1){1'b0}}};
    localparam logic [NLEDS-1:0] SEED_ALL = {NLEDS{1'b1}};

    state_t           state_r;
    logic [1:0]       mode_r;
    logic             pp_dir_s;
    logic [POS_W-1:0] pp_pos_s;
    logic             btn_sync1_r;
    logic             btn_sync2_r;
    logic             btn_rise_s;

    function automatic logic [POS_W-1:0] pos_inc(input logic [POS_W-1:0] p);
        return (p == POS_MAX) ? {POS_W{1'b0}} : p + 1'b1;
    endfunction

    function automatic logic [POS_W-1:0] pos_dec(input logic [POS_W-1:0] p);
        return (p == {POS_W{1'b0}}) ? POS_MAX : p - 1'b1;
    endfunction

    // Ping-pong: reverse at either end so the strobe already moves the new way.
    always_comb begin
        pp_dir_s = o_dir;
        if ((o_pos == POS_MAX) && o_dir) begin
            pp_dir_s = 1'b0;
        end else if ((o_pos == {POS_W{1'b0}}) && !o_dir) begin
            pp_dir_s = 1'b1;
        end else begin
            pp_dir_s = o_dir;
        end
        pp_pos_s = pp_dir_s ? pos_inc(o_pos) : pos_dec(o_pos);
    end

    // Sequencing FSM with registered strobes, position, direction and blanking.
    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) begin
            state_r     <= ST_LOAD;
            mode_r      <= 2'b00;
            o_shift     <= 1'b0;
            o_dir       <= 1'b1;
            o_load      <= 1'b0;
            o_load_data <= {NLEDS{1'b0}};
            o_blank     <= 1'b0;
            o_pos       <= {POS_W{1'b0}};
        end else begin
            o_shift     <= 1'b0;
            o_load      <= 1'b0;
            o_load_data <= {NLEDS{1'b0}};
            case (state_r)
                ST_LOAD: begin
                    mode_r  <= i_mode;
                    o_load  <= 1'b1;
                    o_blank <= 1'b0;
                    case (i_mode)
                        2'b01: begin
                            o_load_data <= SEED_HI;
                            o_pos       <= POS_MAX;
                            o_dir       <= 1'b0;
                        end
                        2'b11: begin
                            o_load_data <= SEED_ALL;
                            o_pos       <= {POS_W{1'b0}};
                            o_dir       <= 1'b1;
                        end
                        default: begin
                            o_load_data <= SEED_LO;
                            o_pos       <= {POS_W{1'b0}};
                            o_dir       <= 1'b1;
                        end
                    endcase
                    state_r <= i_enable ? ST_RUN : ST_HOLD;
                end
                ST_RUN: begin
                    if (!i_enable) begin
                        state_r <= ST_HOLD;
                    end else if (i_tick) begin
                        if (i_mode != mode_r) begin
                            state_r <= ST_LOAD;
                        end else begin
                            case (mode_r)
                                2'b00: begin
                                    o_shift <= 1'b1;
                                    o_dir   <= 1'b1;
                                    o_pos   <= pos_inc(o_pos);
                                end
                                2'b01: begin
                                    o_shift <= 1'b1;
                                    o_dir   <= 1'b0;
                                    o_pos   <= pos_dec(o_pos);
                                end
                                2'b10: begin
                                    o_shift <= 1'b1;
                                    o_dir   <= pp_dir_s;
                                    o_pos   <= pp_pos_s;
                                end
                                default: begin
                                    o_blank <= ~o_blank;
                                end
                            endcase
                        end
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_HOLD: begin
                    if (i_enable) begin
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_HOLD;
                    end
                end
                default: begin
                    state_r <= ST_LOAD;
                end
            endcase
        end
    end

    // Two-flop synchronizer for the asynchronous colour button.
    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) begin
            btn_sync1_r <= 1'b0;
            btn_sync2_r <= 1'b0;
        end else begin
            btn_sync1_r <= i_color_btn;
            btn_sync2_r <= btn_sync1_r;
        end
    end

`ifdef LED_SEQ_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             db_r;
    logic             db_prev_r;
    logic [CNT_W-1:0] db_cnt_r;

    // A new level is accepted only after it has been stable for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) begin
            db_r      <= 1'b0;
            db_prev_r <= 1'b0;
            db_cnt_r  <= {CNT_W{1'b0}};
        end else begin
            db_prev_r <= db_r;
            if (btn_sync2_r == db_r) begin
                db_cnt_r <= {CNT_W{1'b0}};
            end else if (db_cnt_r == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                db_r     <= btn_sync2_r;
                db_cnt_r <= {CNT_W{1'b0}};
            end else begin
                db_cnt_r <= db_cnt_r + 1'b1;
            end
        end
    end

    assign btn_rise_s = db_r & ~db_prev_r;
`else
    logic btn_prev_r;

    // Previous synchronized level for rising-edge detection.
    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) begin
            btn_prev_r <= 1'b0;
        end else begin
            btn_prev_r <= btn_sync2_r;
        end
    end

    assign btn_rise_s = btn_sync2_r & ~btn_prev_r;
`endif

    // Rotate the one-hot colour select on every accepted press.
    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) begin
            o_color_sel <= 3'b001;
        end else if (btn_rise_s) begin
            o_color_sel <= {o_color_sel[1:0], o_color_sel[2]};
        end else begin
            o_color_sel <= o_color_sel;
        end
    end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed table-driven bench for led_seq_ctrl plus hand-written colour/reset sequences.
module tb_led_seq_ctrl;

    logic       clk;
    logic       i_rst;
    logic       i_tick;
    logic       i_enable;
    logic [1:0] i_mode;
    logic       i_color_btn;
    logic       o_shift;
    logic       o_dir;
    logic       o_load;
    logic [3:0] o_load_data;
    logic       o_blank;
    logic [2:0] o_color_sel;
    logic [1:0] o_pos;

    int errors = 0;
    int checks = 0;

`ifdef LED_SEQ_DEBOUNCE_EN
    localparam int LAT = 2 + 16 + 1;
`else
    localparam int LAT = 3;
`endif

    led_seq_ctrl #(.NLEDS(4), .POS_W(2), .DEBOUNCE_CYCLES(16)) dut (
        .clk         (clk),
        .i_rst       (i_rst),
        .i_tick      (i_tick),
        .i_enable    (i_enable),
        .i_mode      (i_mode),
        .i_color_btn (i_color_btn),
        .o_shift     (o_shift),
        .o_dir       (o_dir),
        .o_load      (o_load),
        .o_load_data (o_load_data),
        .o_blank     (o_blank),
        .o_color_sel (o_color_sel),
        .o_pos       (o_pos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       tick;
        logic       en;
        logic [1:0] mode;
        logic       shift;
        logic       load;
        logic [3:0] data;
        logic       dir;
        logic [1:0] pos;
        logic       blank;
    } vec_t;

    vec_t vecs[39];

    function automatic vec_t mk(input logic t, input logic e, input logic [1:0] m,
                                input logic s, input logic l, input logic [3:0] d,
                                input logic dr, input logic [1:0] p, input logic b);
        vec_t v;
        v.tick = t; v.en = e; v.mode = m; v.shift = s; v.load = l;
        v.data = d; v.dir = dr; v.pos = p; v.blank = b;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [2:0] exp_col[4];

    initial begin
        // tick en mode | shift load data dir pos blank
        vecs[0]  = mk(1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b0);
        vecs[1]  = mk(1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd1, 1'b0);
        vecs[2]  = mk(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd1, 1'b0);
        vecs[3]  = mk(1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd2, 1'b0);
        vecs[4]  = mk(1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd3, 1'b0);
        vecs[5]  = mk(1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd0, 1'b0);
        vecs[6]  = mk(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd0, 1'b0);
        vecs[7]  = mk(1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd0, 1'b0);
        vecs[8]  = mk(1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd0, 1'b0);
        vecs[9]  = mk(1'b1, 1'b1, 2'd1, 1'b0, 1'b1, 4'b1000, 1'b0, 2'd3, 1'b0);
        vecs[10] = mk(1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd2, 1'b0);
        vecs[11] = mk(1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd2, 1'b0);
        vecs[12] = mk(1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd2, 1'b0);
        vecs[13] = mk(1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b0);
        vecs[14] = mk(1'b1, 1'b1, 2'd2, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd1, 1'b0);
        vecs[15] = mk(1'b1, 1'b1, 2'd2, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd2, 1'b0);
        vecs[16] = mk(1'b1, 1'b1, 2'd2, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd3, 1'b0);
        vecs[17] = mk(1'b1, 1'b1, 2'd2, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd2, 1'b0);
        vecs[18] = mk(1'b1, 1'b1, 2'd2, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd1, 1'b0);
        vecs[19] = mk(1'b1, 1'b1, 2'd2, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0);
        vecs[20] = mk(1'b1, 1'b1, 2'd2, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd1, 1'b0);
        vecs[21] = mk(1'b1, 1'b1, 2'd2, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd2, 1'b0);
        vecs[22] = mk(1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd2, 1'b0);
        vecs[23] = mk(1'b0, 1'b1, 2'd3, 1'b0, 1'b1, 4'b1111, 1'b1, 2'd0, 1'b0);
        vecs[24] = mk(1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd0, 1'b1);
        vecs[25] = mk(1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd0, 1'b0);
        vecs[26] = mk(1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd0, 1'b0);
        vecs[27] = mk(1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd0, 1'b1);
        vecs[28] = mk(1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd0, 1'b1);
        vecs[29] = mk(1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b0);
        vecs[30] = mk(1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd1, 1'b0);
        vecs[31] = mk(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd1, 1'b0);
        for (int i = 32; i < 37; i++)
            vecs[i] = mk(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd1, 1'b0);
        vecs[37] = mk(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd1, 1'b0);
        vecs[38] = mk(1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd2, 1'b0);

        exp_col[0] = 3'b010;
        exp_col[1] = 3'b100;
        exp_col[2] = 3'b001;
        exp_col[3] = 3'b010;

        i_rst = 1'b0; i_tick = 1'b0; i_enable = 1'b1; i_mode = 2'b00; i_color_btn = 1'b0;
        #12;
        chk("rst_shift", o_shift, 0);
        chk("rst_dir", o_dir, 1);
        chk("rst_load", o_load, 0);
        chk("rst_color", o_color_sel, 3'b001);
        chk("rst_pos", o_pos, 0);
        @(negedge clk);
        i_rst = 1'b1;

        for (int i = 0; i < 39; i++) begin
            i_tick = vecs[i].tick; i_enable = vecs[i].en; i_mode = vecs[i].mode;
            cyc();
            chk($sformatf("v%0d_shift", i), o_shift, vecs[i].shift);
            chk($sformatf("v%0d_load", i), o_load, vecs[i].load);
            chk($sformatf("v%0d_dir", i), o_dir, vecs[i].dir);
            chk($sformatf("v%0d_pos", i), o_pos, vecs[i].pos);
            chk($sformatf("v%0d_blank", i), o_blank, vecs[i].blank);
            if (vecs[i].load)
                chk($sformatf("v%0d_data", i), o_load_data, vecs[i].data);
        end
        i_tick = 1'b0;

`ifdef LED_SEQ_DEBOUNCE_EN
        i_color_btn = 1'b1;
        repeat (5) cyc();
        i_color_btn = 1'b0;
        repeat (30) cyc();
        chk("glitch_rejected", o_color_sel, 3'b001);
`endif

        for (int p = 0; p < 4; p++) begin
            i_color_btn = 1'b1;
            repeat (LAT - 1) cyc();
            chk($sformatf("press%0d_early", p), o_color_sel, (p == 0) ? 3'b001 : exp_col[p-1]);
            cyc();
            chk($sformatf("press%0d_edge", p), o_color_sel, exp_col[p]);
            repeat (25 - LAT) cyc();
            i_color_btn = 1'b0;
            repeat (25) cyc();
            chk($sformatf("release%0d_hold", p), o_color_sel, exp_col[p]);
        end

        chk("pre_rst_pos", o_pos, 2);
        i_rst = 1'b0;
        #2;
        chk("mid_rst_shift", o_shift, 0);
        chk("mid_rst_dir", o_dir, 1);
        chk("mid_rst_load", o_load, 0);
        chk("mid_rst_data", o_load_data, 0);
        chk("mid_rst_blank", o_blank, 0);
        chk("mid_rst_color", o_color_sel, 3'b001);
        chk("mid_rst_pos", o_pos, 0);
        @(negedge clk);
        i_rst = 1'b1;
        cyc();
        chk("post_rst_load", o_load, 1);
        chk("post_rst_data", o_load_data, 4'b0001);
        cyc();
        chk("post_rst_load_once", o_load, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/led_seq_ctrl.md
Name: led_seq_ctrl

Overview:
- Control FSM that sequences the LED shift-register datapath from the rate counter's tick.
- Issues load, shift and direction controls, plus blanking and colour-channel select.
- Supports four motion modes: shift left, shift right, ping-pong and flash.
- Sits between the switch inputs, the counter's valid pulse and the shift register in the LED top level.

Parameters:
- NLEDS, 4, LED/shift-register width; must be ≥2.
- POS_W, 2, width of the position index; must satisfy 2^POS_W ≥ NLEDS.
- DEBOUNCE_CYCLES, 16, stable cycles required on the colour button (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- i_rst  in  1  reset; asynchronous, active-low.
- i_tick  in  1  one-cycle rate pulse from the counter.
- i_enable  in  1  run enable; 0 freezes the sequence.
- i_mode  in  2  00 shift-left, 01 shift-right, 10 ping-pong, 11 flash.
- i_color_btn  in  1  asynchronous button; each press rotates the colour.
- o_shift  out  1  one-cycle shift strobe to the shift register.
- o_dir  out  1  shift direction; 1 = left, 0 = right.
- o_load  out  1  one-cycle parallel-load strobe.
- o_load_data  out  NLEDS  seed for the load; valid while o_load = 1.
- o_blank  out  1  1 forces LEDs dark (flash mode).
- o_color_sel  out  3  one-hot select: 001 blue/plain, 010 red, 100 green.
- o_pos  out  POS_W  index of the lit LED.

Behaviour:
- Reset (i_rst = 0, async):
  - Outputs: o_shift = 0, o_dir = 1, o_load = 0, o_load_data = 0, o_blank = 0, o_color_sel = 001, o_pos = 0.
  - State = LOAD; mode register = 00.
  - Colour synchronizer and edge detector are cleared.
- All outputs are registered.
- States: LOAD, RUN, HOLD.
- LOAD, always one cycle:
  - Captures i_mode into the mode register.
  - Asserts o_load on the next cycle, with seed by mode:
    - 00 and 10: seed = bit0 set, o_pos = 0, o_dir = 1.
    - 01: seed = bit NLEDS-1 set, o_pos = NLEDS-1, o_dir = 0.
    - 11: seed = all ones, o_pos = 0, o_dir = 1.
  - o_blank = 0.
  - Next state: RUN if i_enable = 1, else HOLD.
- RUN, acting on each i_tick:
  - If i_mode ≠ mode register: go to LOAD. No shift is issued on that tick.
  - Mode 00: o_shift = 1 and o_dir = 1 in the following cycle. o_pos increments, wrapping NLEDS-1 → 0.
  - Mode 01: o_shift with o_dir = 0. o_pos decrements, wrapping 0 → NLEDS-1.
  - Mode 10, at a boundary: if (o_pos = NLEDS-1 and o_dir = 1) or (o_pos = 0 and o_dir = 0), flip o_dir in the same cycle as the strobe. The shift goes in the new direction.
  - Mode 10, sequence: for NLEDS = 4, o_pos runs 0,1,2,3,2,1,0,1… with no dwell.
  - Mode 11: o_blank toggles; o_shift stays 0.
- Strobe timing: o_shift / o_load are high for exactly one cycle, 1 cycle after the causing i_tick or LOAD.
- RUN with i_enable = 0: go to HOLD. A tick in the same cycle is ignored.
- HOLD:
  - No strobes; o_pos, o_dir and o_blank are frozen.
  - i_enable = 1 returns to RUN. The first action is on the next tick after return.
  - A mode change while in HOLD is detected on the first tick in RUN.
- Ticks are ignored in LOAD.
- Colour path:
  - i_color_btn passes through a 2-flop synchronizer and rising-edge detect.
  - Each rising edge rotates o_color_sel 001 → 010 → 100 → 001.
  - Latency is 3 clk from the input rising edge to the o_color_sel change.
  - Works independently of the FSM state and i_enable.
- Reset asserted mid-operation clears everything immediately. After release, the first cycle is LOAD.

Optional Feature:
- Macro: LED_SEQ_DEBOUNCE_EN.
- Defined: the synchronized button must be stable for DEBOUNCE_CYCLES consecutive cycles before its new level is accepted.
  - Only an accepted 0 → 1 transition rotates the colour.
  - Glitches shorter than DEBOUNCE_CYCLES are rejected.
  - Latency is 2 + DEBOUNCE_CYCLES + 1 clk.
- Undefined: no debounce logic; 3-clk latency as above.

Test Plan:
- Reset release, i_mode = 00, i_enable = 1 -> one o_load pulse with o_load_data = 0001; then each tick gives one o_shift with o_dir = 1; o_pos goes 1,2,3,0.
- Mode 10, 8 ticks -> o_pos 1,2,3,2,1,0,1,2; o_dir falls in the same cycle as the strobe that takes o_pos 3 → 2.
- Mode 00 → 01 change mid-run -> next tick issues no shift; o_load pulses with data 1000, o_pos = 3, o_dir = 0; next tick gives o_pos = 2.
- Mode 11 -> o_load data 1111; o_blank toggles on every tick; o_shift never asserts.
- i_enable dropped with a tick in the same cycle -> no strobe, o_pos frozen through 5 ticks; re-enable -> resumes from the frozen o_pos.
- Three button presses -> o_color_sel 010, 100, 001, each 3 clk after its edge. With LED_SEQ_DEBOUNCE_EN: a 5-cycle pulse is ignored; a 20-cycle press is accepted. Async reset mid-sequence -> all outputs return to reset values immediately.
